aes_shift_rows_pipe: RTL and testbench
======================================

// Module: aes_shift_rows_pipe
// PURPOSE
//  Parametrised AES ShiftRows round stage. Sits between SubBytes and MixColumns in the round pipeline.
//  Supports a per-transaction forward (encrypt) or inverse (decrypt) row rotation.
//  Carries the round key with an optional RotWord on key row 3, plus Rcon and an empty flag as sideband.
//  Adds valid/ready backpressure, a synchronous flush and a configurable register depth.
// PARAMETERS
//  STAGES      2  register depth from input to output, >=1; latency in cycles when not stalled
//  INV_EN      1  1: mode_in selects forward/inverse; 0: mode_in ignored, always forward
//  ROT_KEY     1  1: key row 3 rotated left one byte (RotWord); 0: key passes unchanged
//  RCON_W      8  width of the Rcon sideband
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  flush      in   1        synchronous clear of all in-flight transactions
//  in_valid   in   1        input transaction present
//  in_ready   out  1        stage accepts input this cycle
//  mode_in    in   1        0 = ShiftRows, 1 = InvShiftRows (used only when INV_EN=1)
//  state_in   in   128      state; byte i = [127-8i -: 8], i = 4*row + col
//  key_in     in   128      round key, same byte layout
//  rcon_in    in   RCON_W   round constant
//  empty_in   in   1        empty-slot sideband
//  out_valid  out  1        output transaction present
//  out_ready  in   1        downstream accepts the output
//  state_out  out  128      rotated state
//  key_out    out  128      key, row 3 rotated when ROT_KEY=1
//  rcon_out   out  RCON_W   delayed rcon_in
//  empty_out  out  1        delayed empty_in
// BEHAVIOUR
//  - Forward transform: out[4r+c] = in[4r+((c+r)%4)]. Inverse: out[4r+c] = in[4r+((c-r)%4)]. Row 0 unchanged.
//  - Key transform (ROT_KEY=1): ko[12+c] = k[12+((c+1)%4)]. Bytes 0..11 pass unchanged. Independent of mode.
//  - Transforms are combinational ahead of stage 0. Stages 1..STAGES-1 are pure delay.
//    Mode travels with the data and is applied at entry only.
//  - Advance signal adv = out_ready | ~out_valid. All stages shift together when adv=1; all hold when adv=0.
//  - Stage 0 loads valid = in_valid & adv.
//  - Bubbles are not compressed; a stage with valid=0 still shifts.
//  - in_ready = adv, combinational from out_ready and out_valid.
//  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//  - Data in a stage with valid=0 is don't-care internally.
//  - Latency is exactly STAGES cycles from an accepted input to out_valid, with out_ready held 1.
//  - Output holds stable (all buses) while out_valid=1 and out_ready=0.
//  - Reset (sync): all valids 0, state_out/key_out 0, rcon_out 0, empty_out 1, in_ready 1 the cycle after.
//  - flush: all valids cleared next edge; data registers untouched. Input offered in the flush cycle is dropped.
//    in_ready is still reported as adv.
//  - reset has priority over flush. Both take effect regardless of out_ready.
//  - Reset or flush mid-stall discards held output; no partial transaction emitted.
//  - STAGES=1: single register; throughput 1 per cycle with out_ready=1.
//  - INV_EN=0: inverse logic not synthesised; mode_in unused.
// TESTING
//  - Fwd: state 000102..0F, mode 0, STAGES=2 -> after 2 cycles state_out = 00010203_05060704_0A0B0809_0F0C0D0E.
//  - Inv: same state, mode 1 -> state_out = 00010203_07040506_0A0B0809_0D0E0F0C.
//    Fwd then inv back-to-back returns the original.
//  - Key: key_in 000102..0F, rcon_in 01, empty_in 0 -> key_out last word 0D0E0F0C, rest unchanged.
//    rcon_out 01 and empty_out 0, aligned with the state.
//  - Backpressure: stream 8 tokens (mode alternating), out_ready random 50%.
//    -> all 8 emerge in order, no loss or duplication, outputs stable while stalled.
//  - Flush/reset: 2 tokens in flight, assert flush 1 cycle -> out_valid 0 next cycle, no stale token later.
//    reset mid-stall -> empty_out=1, outputs 0.
//  - Sweep STAGES=1,3,5 with ROT_KEY=0 -> latency equals STAGES; key_out equals key_in.

Source files
------------

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe
// AES ShiftRows / InvShiftRows round stage with a RotWord'd round key, Rcon and
// empty-slot sideband, valid/ready backpressure, synchronous flush and a
// configurable register depth. Byte i of a 128-bit bus is [127-8i -: 8], i = 4*row + col.
module aes_shift_rows_pipe #(
  parameter int STAGES  = 2,
  parameter int INV_EN  = 1,
  parameter int ROT_KEY = 1,
  parameter int RCON_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode_in,
  input  logic [127:0]      state_in,
  input  logic [127:0]      key_in,
  input  logic [RCON_W-1:0] rcon_in,
  input  logic              empty_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      state_out,
  output logic [127:0]      key_out,
  output logic [RCON_W-1:0] rcon_out,
  output logic              empty_out
);

  // The whole pipe moves as one: it advances whenever the last slot is empty
  // or being drained. Bubbles are carried along, not squeezed out.
  logic adv;

  logic [127:0]      state_x;
  logic [127:0]      key_x;
  logic              inv_sel;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] empty_q;
  logic [127:0]      state_q [STAGES];
  logic [127:0]      key_q   [STAGES];
  logic [RCON_W-1:0] rcon_q  [STAGES];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // With INV_EN=0 the select is a constant zero, so the inverse mux folds away.
  assign inv_sel = (INV_EN != 0) ? mode_in : 1'b0;

  // Row rotation of the state and RotWord of key row 3, applied once at entry.
  always_comb begin
    state_x = '0;
    key_x   = key_in;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (inv_sel)
          state_x[127-8*(4*r+c) -: 8] = state_in[127-8*(4*r+((c+4-r)%4)) -: 8];
        else
          state_x[127-8*(4*r+c) -: 8] = state_in[127-8*(4*r+((c+r)%4)) -: 8];
      end
    end
    if (ROT_KEY != 0) begin
      for (int c = 0; c < 4; c++) begin
        key_x[127-8*(12+c) -: 8] = key_in[127-8*(12+((c+1)%4)) -: 8];
      end
    end
  end

  // Pipeline registers: reset clears everything, flush only kills valids and
  // leaves the data alone, otherwise all stages shift together on adv.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      empty_q <= '1;
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= '0;
        key_q[i]   <= '0;
        rcon_q[i]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      for (int i = STAGES-1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        empty_q[i] <= empty_q[i-1];
        state_q[i] <= state_q[i-1];
        key_q[i]   <= key_q[i-1];
        rcon_q[i]  <= rcon_q[i-1];
      end
      valid_q[0] <= in_valid;
      empty_q[0] <= empty_in;
      state_q[0] <= state_x;
      key_q[0]   <= key_x;
      rcon_q[0]  <= rcon_in;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign empty_out = empty_q[STAGES-1];
  assign state_out = state_q[STAGES-1];
  assign key_out   = key_q[STAGES-1];
  assign rcon_out  = rcon_q[STAGES-1];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe
// Scoreboard bench for aes_shift_rows_pipe: a STAGES=2 instance with all
// features enabled, plus STAGES=1,3,5 instances with ROT_KEY=0 for the latency sweep.
module tb_aes_shift_rows_pipe;

  localparam int STAGES = 2;
  localparam logic [127:0] X_VAL   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FWD_VAL = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
  localparam logic [127:0] INV_VAL = 128'h00010203_07040506_0a0b0809_0d0e0f0c;
  localparam logic [127:0] KEY_VAL = 128'h00010203_04050607_08090a0b_0d0e0f0c;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         mode_in = 1'b0;
  logic         out_ready = 1'b0;
  logic         empty_in = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic [7:0]   rcon_in = '0;
  logic         in_ready, out_valid, empty_out;
  logic [127:0] state_out, key_out;
  logic [7:0]   rcon_out;

  logic         sw_in_ready [3];
  logic         sw_valid [3];
  logic         sw_empty [3];
  logic [127:0] sw_state [3];
  logic [127:0] sw_key [3];
  logic [7:0]   sw_rcon [3];

  typedef struct {
    logic [127:0] st;
    logic [127:0] ky;
    logic [7:0]   rc;
    logic         em;
    int           cyc;
  } tok_t;

  tok_t         sb [$];
  logic [127:0] obs_state [$];
  logic [127:0] obs_key [$];
  logic [7:0]   obs_rcon [$];
  logic         obs_empty [$];

  int total = 0;
  int bad = 0;
  int cycle_no = 0;
  bit check_lat = 1'b0;
  bit accepted = 1'b0;
  bit held = 1'b0;
  logic [127:0] held_state, held_key;
  logic [7:0]   held_rcon;
  logic         held_empty;

  always #5 clock = ~clock;

  aes_shift_rows_pipe #(.STAGES(STAGES), .INV_EN(1), .ROT_KEY(1), .RCON_W(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .mode_in(mode_in),
    .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in), .empty_in(empty_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .key_out(key_out), .rcon_out(rcon_out), .empty_out(empty_out)
  );

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_sweep
      aes_shift_rows_pipe #(.STAGES(2*g+1), .INV_EN(1), .ROT_KEY(0), .RCON_W(8)) u_sw (
        .clock(clock), .reset(reset), .flush(1'b0),
        .in_valid(in_valid), .in_ready(sw_in_ready[g]), .mode_in(mode_in),
        .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in), .empty_in(empty_in),
        .out_valid(sw_valid[g]), .out_ready(1'b1),
        .state_out(sw_state[g]), .key_out(sw_key[g]), .rcon_out(sw_rcon[g]), .empty_out(sw_empty[g])
      );
    end
  endgenerate

  // Reference ShiftRows: each row is a 32-bit word rotated by row bytes.
  function automatic logic [127:0] model_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [31:0]  w;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      w = s[127-32*row -: 32];
      if (!inv) w = (w << (8*row)) | (w >> (32-8*row));
      else      w = (w >> (8*row)) | (w << (32-8*row));
      r[127-32*row -: 32] = w;
    end
    return r;
  endfunction

  // Reference RotWord on the last key word.
  function automatic logic [127:0] model_key(input logic [127:0] k);
    logic [127:0] r;
    r = k;
    r[31:0] = {k[23:0], k[31:24]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then settle and score
  // the handshakes that the coming rising edge will commit.
  task automatic applyStimulus(input logic iv, input logic md, input logic [127:0] st,
                               input logic [127:0] ky, input logic [7:0] rc, input logic em,
                               input logic ordy, input logic fl, input logic rst);
    tok_t e;
    @(negedge clock);
    in_valid = iv; mode_in = md; state_in = st; key_in = ky;
    rcon_in = rc; empty_in = em; out_ready = ordy; flush = fl; reset = rst;
    #1;
    cycle_no++;
    accepted = 1'b0;
    if (held) begin
      checkOutput("hold_state", state_out, held_state);
      checkOutput("hold_key", key_out, held_key);
      checkOutput("hold_rcon", {120'd0, rcon_out}, {120'd0, held_rcon});
      checkOutput("hold_empty", {127'd0, empty_out}, {127'd0, held_empty});
    end
    held = 1'b0;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", {127'd0, out_valid}, 128'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_state", state_out, e.st);
          checkOutput("sb_key", key_out, e.ky);
          checkOutput("sb_rcon", {120'd0, rcon_out}, {120'd0, e.rc});
          checkOutput("sb_empty", {127'd0, empty_out}, {127'd0, e.em});
          if (check_lat) checkOutput("latency", 128'(cycle_no - e.cyc), 128'(STAGES));
        end
        obs_state.push_back(state_out);
        obs_key.push_back(key_out);
        obs_rcon.push_back(rcon_out);
        obs_empty.push_back(empty_out);
      end
      if (in_valid && in_ready) begin
        e.st = model_rows(st, md);
        e.ky = model_key(ky);
        e.rc = rc;
        e.em = em;
        e.cyc = cycle_no;
        sb.push_back(e);
        accepted = 1'b1;
      end
      if (out_valid && !out_ready) begin
        held = 1'b1;
        held_state = state_out; held_key = key_out;
        held_rcon = rcon_out; held_empty = empty_out;
      end
    end
  endtask

  logic [127:0] bp_state [8];
  logic [127:0] bp_key [8];
  logic [7:0]   bp_rc [8];
  logic         bp_em [8];
  logic         rnd;
  bit           seen [3];
  int           c0;
  int           ntok;

  initial begin
    // Reset and post-reset state.
    applyStimulus(0, 0, '0, '0, 8'h00, 0, 1, 0, 1);
    applyStimulus(0, 0, '0, '0, 8'h00, 0, 1, 0, 1);
    applyStimulus(0, 0, '0, '0, 8'h00, 0, 1, 0, 0);
    checkOutput("rst_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("rst_state", state_out, 128'd0);
    checkOutput("rst_key", key_out, 128'd0);
    checkOutput("rst_rcon", {120'd0, rcon_out}, 128'd0);
    checkOutput("rst_empty", {127'd0, empty_out}, 128'd1);

    // Latency sweep across depths 1, 3, 5 with the key passing through.
    check_lat = 1'b1;
    applyStimulus(1, 0, X_VAL, X_VAL, 8'h01, 0, 1, 0, 0);
    c0 = cycle_no;
    for (int k = 0; k < 3; k++) seen[k] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(0, 0, '0, '0, 8'h00, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && sw_valid[k]) begin
          seen[k] = 1'b1;
          checkOutput("sweep_lat", 128'(cycle_no - c0), 128'(2*k+1));
          checkOutput("sweep_state", sw_state[k], FWD_VAL);
          checkOutput("sweep_key", sw_key[k], X_VAL);
          checkOutput("sweep_rcon", {120'd0, sw_rcon[k]}, 128'h01);
          checkOutput("sweep_empty", {127'd0, sw_empty[k]}, 128'd0);
        end
      end
    end
    for (int k = 0; k < 3; k++) checkOutput("sweep_seen", {127'd0, seen[k]}, 128'd1);

    // Directed vectors: forward, inverse, and inverse of the forward result.
    obs_state.delete(); obs_key.delete(); obs_rcon.delete(); obs_empty.delete();
    applyStimulus(1, 0, X_VAL, X_VAL, 8'h01, 0, 1, 0, 0);
    applyStimulus(1, 1, X_VAL, X_VAL, 8'h02, 1, 1, 0, 0);
    applyStimulus(1, 1, FWD_VAL, X_VAL, 8'h03, 0, 1, 0, 0);
    for (int n = 0; n < 10 && obs_state.size() < 3; n++)
      applyStimulus(0, 0, '0, '0, 8'h00, 1, 1, 0, 0);
    checkOutput("dir_count", 128'(obs_state.size()), 128'd3);
    if (obs_state.size() >= 3) begin
      checkOutput("dir_fwd", obs_state[0], FWD_VAL);
      checkOutput("dir_key", obs_key[0], KEY_VAL);
      checkOutput("dir_rcon", {120'd0, obs_rcon[0]}, 128'h01);
      checkOutput("dir_empty", {127'd0, obs_empty[0]}, 128'd0);
      checkOutput("dir_inv", obs_state[1], INV_VAL);
      checkOutput("dir_roundtrip", obs_state[2], X_VAL);
    end

    // Backpressure stream of 8 tokens with random out_ready.
    check_lat = 1'b0;
    obs_state.delete(); obs_key.delete(); obs_rcon.delete(); obs_empty.delete();
    for (int i = 0; i < 8; i++) begin
      bp_state[i] = {$urandom, $urandom, $urandom, $urandom};
      bp_key[i] = {$urandom, $urandom, $urandom, $urandom};
      bp_rc[i] = 8'($urandom);
      bp_em[i] = 1'($urandom);
    end
    ntok = 0;
    for (int n = 0; n < 300 && (ntok < 8 || sb.size() > 0); n++) begin
      rnd = 1'($urandom_range(0, 1));
      if (ntok < 8)
        applyStimulus(1, ntok[0], bp_state[ntok], bp_key[ntok], bp_rc[ntok], bp_em[ntok], rnd, 0, 0);
      else
        applyStimulus(0, 0, '0, '0, 8'h00, 1, rnd, 0, 0);
      if (accepted) ntok++;
    end
    checkOutput("bp_count", 128'(obs_state.size()), 128'd8);
    checkOutput("bp_left", 128'(sb.size()), 128'd0);

    // Flush with two tokens in flight; the token offered with flush is dropped.
    applyStimulus(1, 0, bp_state[0], bp_key[0], 8'h11, 0, 1, 0, 0);
    applyStimulus(1, 1, bp_state[1], bp_key[1], 8'h22, 0, 1, 0, 0);
    applyStimulus(1, 0, bp_state[2], bp_key[2], 8'h33, 0, 0, 1, 0);
    applyStimulus(0, 0, '0, '0, 8'h00, 1, 1, 0, 0);
    checkOutput("flush_valid", {127'd0, out_valid}, 128'd0);
    for (int n = 0; n < 6; n++) applyStimulus(0, 0, '0, '0, 8'h00, 1, 1, 0, 0);

    // Reset while the output is stalled.
    applyStimulus(1, 0, bp_state[3], bp_key[3], 8'h44, 0, 0, 0, 0);
    for (int n = 0; n < 10 && !out_valid; n++) applyStimulus(0, 0, '0, '0, 8'h00, 1, 0, 0, 0);
    checkOutput("stall_valid", {127'd0, out_valid}, 128'd1);
    applyStimulus(0, 0, '0, '0, 8'h00, 1, 0, 0, 1);
    applyStimulus(0, 0, '0, '0, 8'h00, 1, 0, 0, 0);
    checkOutput("rst2_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst2_state", state_out, 128'd0);
    checkOutput("rst2_key", key_out, 128'd0);
    checkOutput("rst2_rcon", {120'd0, rcon_out}, 128'd0);
    checkOutput("rst2_empty", {127'd0, empty_out}, 128'd1);
    checkOutput("rst2_ready", {127'd0, in_ready}, 128'd1);
    for (int n = 0; n < 4; n++) applyStimulus(0, 0, '0, '0, 8'h00, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
